// File: rtl/multiplicador_seq_4bits_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// State encoding and counter sizing helper.
package multiplicador_seq_4bits_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_e;

   // Bits needed to count 0..width inclusive
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/somador4bits.sv
// 4-bit ripple-carry full-adder chain.
// Used as a slice of the multiplier's add datapath.
module somador4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] c;

   // Ripple the carry through four full adders
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]     = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end

endmodule

// File: rtl/multiplicador_seq_4bits.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Optional MULT_ZERO_SKIP_EN: zero operands complete in one cycle.
module multiplicador_seq_4bits
   import multiplicador_seq_4bits_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int NSL   = WIDTH / 4;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic [NSL:0]         carry;
   logic                 skip;
   logic                 last;

   assign addend   = q_q[0] ? mcand_q : '0;
   assign carry[0] = 1'b0;
   assign last     = (count_q == LAST);

`ifdef MULT_ZERO_SKIP_EN
   assign skip = (a == '0) || (b == '0);
`else
   assign skip = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NSL; gi++) begin : g_add
         somador4bits u_add (
            .a    (acc_q[4*gi +: 4]),
            .b    (addend[4*gi +: 4]),
            .cin  (carry[gi]),
            .s    (sum[4*gi +: 4]),
            .cout (carry[gi + 1])
         );
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept in idle, leave after the last iteration
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start && !skip) state_d = ST_CALC;
         ST_CALC: if (last)           state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q == ST_CALC);
      done = done_q;
      p    = p_q;
   end

   // Datapath next values: load, shift-add iteration, product capture
   always_comb begin
      mcand_d = mcand_q;
      q_d     = q_q;
      acc_d   = acc_q;
      count_d = count_q;
      p_d     = p_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (skip) begin
                  p_d    = '0;
                  done_d = 1'b1;
               end else begin
                  mcand_d = a;
                  q_d     = b;
                  acc_d   = '0;
                  count_d = '0;
               end
            end
         end
         ST_CALC: begin
            acc_d   = {carry[NSL], sum[WIDTH-1:1]};
            q_d     = {sum[0], q_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (last) begin
               p_d    = {acc_d, q_d};
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         mcand_q <= mcand_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_multiplicador_seq_4bits.sv
// Scoreboard bench for multiplicador_seq_4bits.
// Honours MULT_ZERO_SKIP_EN for zero-operand latency.
module tb_multiplicador_seq_4bits;

   localparam int W = 4;

`ifdef MULT_ZERO_SKIP_EN
   localparam int ZK = 0;
`else
   localparam int ZK = W;
`endif

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a     = '0;
   logic [W-1:0]   b     = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   int             n_cmp = 0;
   int             n_bad = 0;
   logic [2*W-1:0] sb[$];
   logic [2*W-1:0] last_exp = '0;
   logic           prev_done = 1'b0;

   always #5 clk = ~clk;

   multiplicador_seq_4bits #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pop on done, enforce single-cycle done and p hold
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            chk("done_width", {31'd0, prev_done}, 0);
            if (sb.size() == 0) begin
               chk("unexpected_done", {31'd0, done}, 0);
            end else begin
               last_exp = sb.pop_front();
               chk("product", {24'd0, p}, {24'd0, last_exp});
            end
         end else begin
            chk("p_stable", {24'd0, p}, {24'd0, last_exp});
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // Issue one op; caller is at posedge+1. Returns in the done cycle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2*W-1:0] exp, input int exp_k,
                         input bit poke);
      int k;
      bit got;
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      k     = 0;
      got   = 1'b0;
      while (!got && k < 40) begin
         if (done) begin
            got = 1'b1;
         end else begin
            chk("busy_during", {31'd0, busy}, 1);
            if (poke && k == 2) begin
               start = 1'b1;
               a     = 4'd9;
               b     = 4'd9;
            end else begin
               start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
         end
      end
      start = 1'b0;
      chk("timeout", {31'd0, got}, 1);
      chk("latency", k, exp_k);
      chk("busy_at_done", {31'd0, busy}, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      sb.delete();
      last_exp = '0;
      idle(2);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_p", {24'd0, p}, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2*W-1:0] g;
      logic [W-1:0]   ea;
      logic [W-1:0]   eb;

      do_reset();
      idle(1);

      run_op(4'd15, 4'd15, 8'hE1, W, 1'b0);
      idle(1);

      run_op(4'd7, 4'd3, 8'd21, W, 1'b0);
      run_op(4'd12, 4'd11, 8'd132, W, 1'b0);
      idle(2);

      run_op(4'd5, 4'd6, 8'd30, W, 1'b1);
      idle(2);

      run_op(4'd0, 4'd9, 8'd0, ZK, 1'b0);
      idle(2);

      // Abort 13*13 with reset at its third edge
      a     = 4'd13;
      b     = 4'd13;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idle(1);
      chk("busy_before_abort", {31'd0, busy}, 1);
      @(posedge clk);
      rst_n    = 1'b0;
      last_exp = '0;
      #1;
      chk("abort_p", {24'd0, p}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_done", {31'd0, done}, 0);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      chk("abort_idle_busy", {31'd0, busy}, 0);

      run_op(4'd2, 4'd3, 8'd6, W, 1'b0);
      idle(1);

      // All pairs back-to-back against a golden product
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            ea = W'(i);
            eb = W'(j);
            g  = 8'(i * j);
            run_op(ea, eb, g, (i == 0 || j == 0) ? ZK : W, 1'b0);
         end
      end
      idle(4);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
